// File: rtl/jtframe_prog_packer.sv
// Byte-stream to SDRAM programming adapter: region address remap, 4-entry
// write FIFO, download completion pulse, byte count, checksum, overflow flag.
module jtframe_prog_packer #(
    parameter logic [21:0] R1_START  = 22'h10_0000,
    parameter logic [21:0] R2_START  = 22'h20_0000,
    parameter logic [21:0] R1_OFFSET = 22'h08_0000,
    parameter logic [21:0] R2_OFFSET = 22'h10_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        dwnld_busy,
    output logic        dwnld_done,
    output logic [21:0] byte_cnt,
    output logic [15:0] checksum,
    output logic        overflow
);

    localparam int unsigned AW    = 22;
    localparam int unsigned DW    = 8;
    localparam int unsigned MW    = 2;
    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    state_t        state, state_next;
    entry_t        mem [DEPTH];
    entry_t        new_entry;
    logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [AW-1:0] map_addr;
    logic          fifo_empty, fifo_full, accept, retire, drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == PW'(3'b100));
    assign accept     = (state == ACTIVE) && ioctl_wr && !fifo_full;
    assign drop       = (state == ACTIVE) && ioctl_wr && fifo_full;
    assign retire     = prog_we && prog_rdy;
    assign rd_next    = rd_ptr + PW'(retire);

    // Byte address to SDRAM word address, highest region first
    always_comb begin
        map_addr = ioctl_addr >> 1;
        if (ioctl_addr >= R2_START)
            map_addr = AW'((ioctl_addr - R2_START) >> 1) + R2_OFFSET;
        else if (ioctl_addr >= R1_START)
            map_addr = AW'((ioctl_addr - R1_START) >> 1) + R1_OFFSET;
    end

    assign new_entry = '{addr: map_addr,
                         data: ioctl_data,
                         mask: ioctl_addr[0] ? 2'b01 : 2'b10};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (downloading)  state_next = ACTIVE;
            ACTIVE:  if (!downloading) state_next = DRAIN;
            DRAIN:   if (fifo_empty && !prog_we) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FIFO storage, written only on acceptance (never while full)
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[1:0]] <= new_entry;
    end

    // Pointers and output register; head entry shown without being removed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= 2'b11;
        end else begin
            rd_ptr  <= rd_next;
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            prog_we <= (rd_next != wr_ptr);
            if (rd_next != wr_ptr) begin
                prog_addr <= mem[rd_next[1:0]].addr;
                prog_data <= mem[rd_next[1:0]].data;
                prog_mask <= mem[rd_next[1:0]].mask;
            end
        end
    end

    // Download statistics, cleared when a new download starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            checksum <= '0;
            overflow <= 1'b0;
        end else if (state == IDLE && downloading) begin
            byte_cnt <= '0;
            checksum <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                byte_cnt <= byte_cnt + AW'(1);
                checksum <= checksum + CW'(ioctl_data);
            end
            if (drop) overflow <= 1'b1;
        end
    end

    // Status flags registered from the next state so they track the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwnld_busy <= 1'b0;
            dwnld_done <= 1'b0;
        end else begin
            dwnld_busy <= (state_next == ACTIVE) || (state_next == DRAIN);
            dwnld_done <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_jtframe_prog_packer.sv
// Self-checking bench for jtframe_prog_packer with a queue-based write model.
module tb_jtframe_prog_packer;

    localparam int R1 = 32'h10_0000;
    localparam int R2 = 32'h20_0000;
    localparam int O1 = 32'h08_0000;
    localparam int O2 = 32'h10_0000;

    typedef struct {
        logic [21:0] a;
        logic [7:0]  d;
        logic [1:0]  m;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [21:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_rdy = 1'b0;
    logic        dwnld_busy, dwnld_done;
    logic [21:0] byte_cnt;
    logic [15:0] checksum;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    wr_t got[$];
    wr_t exp_q[$];

    jtframe_prog_packer dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_rdy(prog_rdy), .dwnld_busy(dwnld_busy),
        .dwnld_done(dwnld_done), .byte_cnt(byte_cnt), .checksum(checksum),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Record each handshake that will retire at the next rising edge
    always @(negedge clk) begin
        if (rst_n && prog_we && prog_rdy)
            got.push_back('{a: prog_addr, d: prog_data, m: prog_mask});
    end

    function automatic wr_t model(input int a, input int d);
        wr_t w;
        int word;
        if (a >= R2)      word = (a - R2) / 2 + O2;
        else if (a >= R1) word = (a - R1) / 2 + O1;
        else              word = a / 2;
        w.a = 22'(word % 32'h40_0000);
        w.d = 8'(d);
        w.m = (a % 2 == 1) ? 2'b01 : 2'b10;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_download();
        got.delete();
        exp_q.delete();
        downloading = 1'b1;
        tick();
    endtask

    task automatic strobe(input int a, input int d);
        ioctl_addr = 22'(a);
        ioctl_data = 8'(d);
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    // End the download with prog_rdy high and count completion pulses
    task automatic finish_download(output int pulses);
        pulses = 0;
        downloading = 1'b0;
        prog_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dwnld_done) pulses++;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({prog_we, prog_addr, prog_data, prog_mask} !== {1'b0, 22'h0, 8'h0, 2'b11}) begin
            n_fail++;
            $display("FAIL reset_prog: got we=%b a=%h d=%h m=%b want 0/0/0/11",
                     prog_we, prog_addr, prog_data, prog_mask);
        end
        n_checks++;
        if ({dwnld_busy, dwnld_done, byte_cnt, checksum, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b done=%b cnt=%h sum=%h ovf=%b want all 0",
                     dwnld_busy, dwnld_done, byte_cnt, checksum, overflow);
        end
    endtask

    task automatic test_basic();
        int pulses;
        start_download();
        prog_rdy = 1'b1;
        n_checks++;
        if (dwnld_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b want 1", dwnld_busy);
        end
        strobe(0, 8'h12); exp_q.push_back(model(0, 8'h12));
        strobe(1, 8'h34); exp_q.push_back(model(1, 8'h34));
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (got.size() !== 2 || got[0] !== exp_q[0] || got[1] !== exp_q[1]) begin
            n_fail++;
            $display("FAIL basic_writes: got %0d writes (first a=%h d=%h m=%b) want 2 (a=0 d=12 m=10, a=0 d=34 m=01)",
                     got.size(), prog_addr, prog_data, prog_mask);
        end
        n_checks++;
        if (byte_cnt !== 22'd2 || checksum !== 16'h0046) begin
            n_fail++;
            $display("FAIL basic_counts: cnt=%0d sum=%h want 2/0046", byte_cnt, checksum);
        end
        finish_download(pulses);
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL basic_done: %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_region();
        int pulses;
        start_download();
        prog_rdy = 1'b1;
        strobe(32'h10_0003, 8'hAA); exp_q.push_back(model(32'h10_0003, 8'hAA));
        strobe(32'h20_0000, 8'hBB); exp_q.push_back(model(32'h20_0000, 8'hBB));
        finish_download(pulses);
        n_checks++;
        if (got.size() !== 2) begin
            n_fail++;
            $display("FAIL region_count: got %0d want 2", got.size());
        end else begin
            n_checks++;
            if (got[0] !== exp_q[0] || got[0].a !== 22'h08_0001) begin
                n_fail++;
                $display("FAIL region1: got a=%h d=%h m=%b want a=080001 d=aa m=01",
                         got[0].a, got[0].d, got[0].m);
            end
            n_checks++;
            if (got[1] !== exp_q[1] || got[1].a !== 22'h10_0000) begin
                n_fail++;
                $display("FAIL region2: got a=%h d=%h m=%b want a=100000 d=bb m=10",
                         got[1].a, got[1].d, got[1].m);
            end
        end
    endtask

    task automatic test_drain();
        int retired_at_done = -1;
        int pulses = 0;
        int post = 0;
        bit busy_ok = 1'b1;
        start_download();
        prog_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe(32'h100 + i, 8'h50 + i);
            exp_q.push_back(model(32'h100 + i, 8'h50 + i));
        end
        downloading = 1'b0;
        for (int i = 0; i < 60 && post < 3; i++) begin
            prog_rdy = (i % 3 == 2);
            tick();
            if (got.size() < 3 && dwnld_busy !== 1'b1) busy_ok = 1'b0;
            if (dwnld_done) begin
                pulses++;
                if (retired_at_done < 0) retired_at_done = got.size();
            end
            if (pulses > 0) post++;
        end
        prog_rdy = 1'b0;
        n_checks++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL drain_busy: busy dropped before last retire");
        end
        n_checks++;
        if (pulses != 1 || retired_at_done != 3) begin
            n_fail++;
            $display("FAIL drain_done: pulses=%0d retired_at_done=%0d want 1/3",
                     pulses, retired_at_done);
        end
        n_checks++;
        if (dwnld_busy !== 1'b0 || dwnld_done !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_idle: busy=%b done=%b want 0/0", dwnld_busy, dwnld_done);
        end
        n_checks++;
        if (got.size() !== 3 || got[0] !== exp_q[0] || got[2] !== exp_q[2]) begin
            n_fail++;
            $display("FAIL drain_writes: got %0d want 3 in order", got.size());
        end
    endtask

    task automatic test_ignored();
        int pulses;
        logic [21:0] cnt0;
        cnt0 = byte_cnt;
        got.delete();
        strobe(32'h5, 8'h77);
        strobe(32'h6, 8'h78);
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (got.size() !== 0 || byte_cnt !== cnt0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_idle: writes=%0d cnt=%0d ovf=%b want 0/%0d/0",
                     got.size(), byte_cnt, overflow, cnt0);
        end
        start_download();
        prog_rdy = 1'b0;
        strobe(32'h40, 8'h11); exp_q.push_back(model(32'h40, 8'h11));
        downloading = 1'b0;
        tick();
        strobe(32'h41, 8'h22);
        strobe(32'h42, 8'h33);
        finish_download(pulses);
        n_checks++;
        if (got.size() !== 1 || got[0] !== exp_q[0] || byte_cnt !== 22'd1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_drain: writes=%0d cnt=%0d ovf=%b want 1/1/0",
                     got.size(), byte_cnt, overflow);
        end
    endtask

    task automatic test_backpressure();
        int pulses;
        int bad = 0;
        start_download();
        prog_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            strobe(32'h300 + 2 * i, 8'hC0 + i);
            if (i < 4) exp_q.push_back(model(32'h300 + 2 * i, 8'hC0 + i));
        end
        n_checks++;
        if (byte_cnt !== 22'd4 || overflow !== 1'b1 || got.size() !== 0) begin
            n_fail++;
            $display("FAIL bp_accept: cnt=%0d ovf=%b writes=%0d want 4/1/0",
                     byte_cnt, overflow, got.size());
        end
        finish_download(pulses);
        for (int i = 0; i < 4 && i < got.size(); i++)
            if (got[i] !== exp_q[i]) bad++;
        n_checks++;
        if (got.size() !== 4 || bad != 0) begin
            n_fail++;
            $display("FAIL bp_release: writes=%0d bad=%0d want 4/0", got.size(), bad);
        end
        n_checks++;
        if (pulses != 1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: pulses=%0d ovf=%b want 1/1", pulses, overflow);
        end
    endtask

    task automatic test_random();
        int occ = 0;
        int cnt = 0;
        int sum = 0;
        bit ovf = 1'b0;
        int pulses;
        int bad = 0;
        int a, d;
        bit wr, ret;
        start_download();
        for (int i = 0; i < 300; i++) begin
            wr = ($urandom_range(0, 1) == 1);
            prog_rdy = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 2))
                0:       a = $urandom_range(0, R1 - 1);
                1:       a = $urandom_range(R1, R2 - 1);
                default: a = $urandom_range(R2, 32'h3F_FFFF);
            endcase
            d = $urandom_range(0, 255);
            ioctl_addr = 22'(a);
            ioctl_data = 8'(d);
            ioctl_wr   = wr;
            ret = prog_we && prog_rdy;
            if (wr && occ < 4) begin
                exp_q.push_back(model(a, d));
                occ++;
                cnt++;
                sum = (sum + d) % 65536;
            end else if (wr) begin
                ovf = 1'b1;
            end
            if (ret) occ--;
            tick();
        end
        ioctl_wr = 1'b0;
        finish_download(pulses);
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            if (got[i] !== exp_q[i]) bad++;
        n_checks++;
        if (got.size() !== exp_q.size() || bad != 0) begin
            n_fail++;
            $display("FAIL rand_writes: got %0d want %0d, %0d differ",
                     got.size(), exp_q.size(), bad);
        end
        n_checks++;
        if (byte_cnt !== 22'(cnt) || checksum !== 16'(sum) || overflow !== ovf) begin
            n_fail++;
            $display("FAIL rand_stats: cnt=%0d sum=%h ovf=%b want %0d/%h/%b",
                     byte_cnt, checksum, overflow, cnt, 16'(sum), ovf);
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL rand_done: %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        start_download();
        prog_rdy = 1'b0;
        strobe(32'h10, 8'h01);
        strobe(32'h11, 8'h02);
        while (prog_we !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        n_checks++;
        if (prog_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_setup: prog_we=%b want 1", prog_we);
        end
        #2 rst_n = 1'b0;
        downloading = 1'b0;
        #1;
        n_checks++;
        if ({prog_we, prog_addr, prog_data, prog_mask, dwnld_busy, dwnld_done,
             byte_cnt, checksum, overflow} !== {1'b0, 22'h0, 8'h0, 2'b11, 1'b0,
             1'b0, 22'h0, 16'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_values: we=%b a=%h d=%h m=%b busy=%b cnt=%0d sum=%h",
                     prog_we, prog_addr, prog_data, prog_mask, dwnld_busy, byte_cnt, checksum);
        end
        tick();
        rst_n = 1'b1;
        prog_rdy = 1'b1;
        got.delete();
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (got.size() !== 0 || prog_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_nowrite: writes=%0d we=%b want 0/0", got.size(), prog_we);
        end
    endtask

    initial begin
        #12 rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_region();
        test_drain();
        test_ignored();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
